iobus_char_tx: RTL and testbench

- Slave-side IO-bus device that receives DATAO words from the processor and serialises each 36-bit word into six 6-bit characters on a valid/ready stream.
- Provides CONO/CONI status registers, DATAI readback and a priority-interrupt request on completion.
- Connects to the device side of the IO-bus master interface; the tx_* stream feeds a character sink such as a punch or serial line model.

---
 rtl/iobus_char_tx_if.sv | 38 +++
 rtl/iobus_char_tx.sv | 169 ++++++++++++++++
 tb/tb_iobus_char_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/iobus_char_tx_if.sv
// IO-bus device-side signal bundle plus the outgoing character stream.
// The slave modport is the device; the master modport is the processor/sink side.
interface iobus_char_tx_if;
  logic        iobus_iob_poweron;
  logic        iobus_iob_reset;
  logic        iobus_datao_clear;
  logic        iobus_datao_set;
  logic        iobus_cono_clear;
  logic        iobus_cono_set;
  logic        iobus_iob_fm_datai;
  logic        iobus_iob_fm_status;
  logic        iobus_rdi_pulse;
  logic [3:9]  iobus_ios;
  logic [0:35] iobus_iob_in;
  logic [1:7]  iobus_pi_req;
  logic [0:35] iobus_iob_out;
  logic        iobus_dr_split;
  logic        iobus_rdi_data;
  logic [0:5]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output iobus_iob_poweron, iobus_iob_reset, iobus_datao_clear, iobus_datao_set,
           iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status,
           iobus_rdi_pulse, iobus_ios, iobus_iob_in, tx_ready,
    input  iobus_pi_req, iobus_iob_out, iobus_dr_split, iobus_rdi_data,
           tx_data, tx_valid
  );

  modport slave (
    input  iobus_iob_poweron, iobus_iob_reset, iobus_datao_clear, iobus_datao_set,
           iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status,
           iobus_rdi_pulse, iobus_ios, iobus_iob_in, tx_ready,
    output iobus_pi_req, iobus_iob_out, iobus_dr_split, iobus_rdi_data,
           tx_data, tx_valid
  );
endinterface

// File: rtl/iobus_char_tx.sv
// IO-bus character transmitter: serialises each DATAO word into six 6-bit
// characters (MSB first) on a valid/ready stream, with CONO/CONI and PI request.
module iobus_char_tx #(
  parameter logic [3:9] DEVCODE = 7'o14
) (
  input logic            clk,
  input logic            reset,
  iobus_char_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    LAST = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [0:35] buf_q, buf_d;
  logic [0:2]  pia_q, pia_d;
  logic [0:2]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [1:7]  pi_req_q, pi_req_d;

  logic        sel;
  logic        clear_all;
  logic        datao_clr;
  logic        datao_set;
  logic        cono_clr;
  logic        cono_set;
  logic [0:35] status_word;
  logic [0:35] iob_out;
  logic [0:5]  tx_char;
  logic        unused_rdi;

  always_comb begin
    sel       = (bus.iobus_ios == DEVCODE);
    clear_all = !reset || !bus.iobus_iob_poweron || bus.iobus_iob_reset;
    datao_clr = sel && bus.iobus_datao_clear;
    datao_set = sel && bus.iobus_datao_set;
    cono_clr  = sel && bus.iobus_cono_clear;
    cono_set  = sel && bus.iobus_cono_set;
  end

  // Next-state: FSM and DATAO first, CONO applied on top, bus clear last.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    pia_d    = pia_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    pi_req_d = '0;

    case (state_q)
      IDLE: begin
        if (datao_set) state_d = SEND;
      end
      SEND: begin
        if (bus.tx_ready) begin
          if (cnt_q == 3'd5) state_d = LAST;
          else               cnt_d   = cnt_q + 3'd1;
        end
      end
      LAST: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (busy_q) begin
      if (datao_clr || datao_set) ovf_d = 1'b1;
    end else begin
      if (datao_clr) buf_d = '0;
      if (datao_set) begin
        buf_d  = buf_d | bus.iobus_iob_in;
        busy_d = 1'b1;
        done_d = 1'b0;
        cnt_d  = '0;
      end
    end

    if (cono_clr) begin
      pia_d  = '0;
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (cono_set) begin
      pia_d = pia_d | bus.iobus_iob_in[33:35];
      if (bus.iobus_iob_in[32]) begin
        done_d = 1'b0;
        ovf_d  = 1'b0;
      end
    end

    if (clear_all) begin
      state_d = IDLE;
      buf_d   = '0;
      pia_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    // PI request is registered from next-state so it tracks done without lag.
    for (int n = 1; n <= 7; n++) begin
      pi_req_d[n] = done_d && (pia_d == 3'(n));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      pia_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pi_req_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      pia_q    <= pia_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      pi_req_q <= pi_req_d;
    end
  end

  always_comb begin
    case (cnt_q)
      3'd0:    tx_char = buf_q[0:5];
      3'd1:    tx_char = buf_q[6:11];
      3'd2:    tx_char = buf_q[12:17];
      3'd3:    tx_char = buf_q[18:23];
      3'd4:    tx_char = buf_q[24:29];
      default: tx_char = buf_q[30:35];
    endcase
  end

  always_comb begin
    status_word        = '0;
    status_word[30]    = ovf_q;
    status_word[31]    = done_q;
    status_word[32]    = busy_q;
    status_word[33:35] = pia_q;

    iob_out = '0;
    if (sel && bus.iobus_iob_fm_datai)  iob_out = iob_out | buf_q;
    if (sel && bus.iobus_iob_fm_status) iob_out = iob_out | status_word;
  end

  assign unused_rdi         = bus.iobus_rdi_pulse;
  assign bus.iobus_iob_out  = iob_out;
  assign bus.iobus_pi_req   = pi_req_q;
  assign bus.iobus_dr_split = 1'b0;
  assign bus.iobus_rdi_data = 1'b0;
  assign bus.tx_valid       = (state_q == SEND);
  assign bus.tx_data        = (state_q == SEND) ? tx_char : 6'd0;

endmodule

// File: tb/tb_iobus_char_tx.sv
// Directed self-checking bench for iobus_char_tx: CONO/DATAO/CONI traffic,
// stalled and unstalled character streams, overrun, deselect and bus reset.
module tb_iobus_char_tx;

  localparam logic [3:9]  DEV  = 7'o14;
  localparam logic [35:0] WORD = 36'o010203040506;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  logic [35:0] v;

  iobus_char_tx_if bus ();

  iobus_char_tx #(.DEVCODE(DEV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [35:0] observed,
                             input logic [35:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0o expected %0o", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle bus pulses with the given data word on iob_in.
  task automatic applyStimulus(input logic dc, input logic ds, input logic cc,
                               input logic cs, input logic [35:0] data);
    bus.iobus_iob_in      = data;
    bus.iobus_datao_clear = dc;
    bus.iobus_datao_set   = ds;
    bus.iobus_cono_clear  = cc;
    bus.iobus_cono_set    = cs;
    tick();
    bus.iobus_datao_clear = 1'b0;
    bus.iobus_datao_set   = 1'b0;
    bus.iobus_cono_clear  = 1'b0;
    bus.iobus_cono_set    = 1'b0;
  endtask

  task automatic readConi(output logic [35:0] val);
    bus.iobus_iob_fm_status = 1'b1;
    #1;
    val = bus.iobus_iob_out;
    bus.iobus_iob_fm_status = 1'b0;
  endtask

  task automatic readDatai(output logic [35:0] val);
    bus.iobus_iob_fm_datai = 1'b1;
    #1;
    val = bus.iobus_iob_out;
    bus.iobus_iob_fm_datai = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset                   = 1'b0;
    bus.iobus_iob_poweron   = 1'b1;
    bus.iobus_iob_reset     = 1'b0;
    bus.iobus_datao_clear   = 1'b0;
    bus.iobus_datao_set     = 1'b0;
    bus.iobus_cono_clear    = 1'b0;
    bus.iobus_cono_set      = 1'b0;
    bus.iobus_iob_fm_datai  = 1'b0;
    bus.iobus_iob_fm_status = 1'b0;
    bus.iobus_rdi_pulse     = 1'b0;
    bus.iobus_ios           = DEV;
    bus.iobus_iob_in        = '0;
    bus.tx_ready            = 1'b0;

    repeat (2) tick();
    reset = 1'b1;
    $display("[TB] reset released");

    readConi(v);
    checkOutput("reset_coni", v, 36'o0);
    checkOutput("reset_pi_req", 36'(bus.iobus_pi_req), 36'd0);
    checkOutput("reset_tx_valid", 36'(bus.tx_valid), 36'd0);
    checkOutput("reset_tx_data", 36'(bus.tx_data), 36'd0);
    checkOutput("dr_split", 36'(bus.iobus_dr_split), 36'd0);

    // Unstalled transfer on PI channel 3.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 36'o3);
    bus.tx_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, WORD);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("fast_valid%0d", i), 36'(bus.tx_valid), 36'd1);
      checkOutput($sformatf("fast_char%0d", i), 36'(bus.tx_data), 36'(i + 1));
      tick();
    end
    checkOutput("fast_last_valid", 36'(bus.tx_valid), 36'd0);
    tick();
    checkOutput("fast_pi_req", 36'(bus.iobus_pi_req), 36'(7'b0010000));
    readConi(v);
    checkOutput("fast_coni", v, 36'o23);
    readDatai(v);
    checkOutput("fast_datai", v, WORD);

    // Stalled transfer: ready high one cycle in four.
    bus.tx_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, WORD);
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < 3; s++) begin
        checkOutput($sformatf("stall_char%0d_%0d", k, s), 36'(bus.tx_data), 36'(k + 1));
        tick();
      end
      bus.tx_ready = 1'b1;
      checkOutput($sformatf("stall_valid%0d", k), 36'(bus.tx_valid), 36'd1);
      tick();
      bus.tx_ready = 1'b0;
    end
    readConi(v);
    checkOutput("stall_coni_last", v, 36'o13);
    tick();
    readConi(v);
    checkOutput("stall_coni_done", v, 36'o23);

    // Overrun: DATAO set during SEND.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, WORD);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 36'o777777777777);
    readDatai(v);
    checkOutput("ovf_datai", v, WORD);
    readConi(v);
    checkOutput("ovf_coni_busy", v, 36'o53);
    checkOutput("ovf_char0", 36'(bus.tx_data), 36'o01);
    bus.tx_ready = 1'b1;
    repeat (7) tick();
    readConi(v);
    checkOutput("ovf_coni_done", v, 36'o63);
    checkOutput("ovf_pi_req", 36'(bus.iobus_pi_req), 36'(7'b0010000));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 36'o10);
    readConi(v);
    checkOutput("ack_coni", v, 36'o3);
    checkOutput("ack_pi_req", 36'(bus.iobus_pi_req), 36'd0);

    // Deselected device ignores everything.
    bus.iobus_ios           = 7'o15;
    bus.iobus_iob_fm_datai  = 1'b1;
    bus.iobus_iob_fm_status = 1'b1;
    bus.iobus_iob_in        = 36'o777777777777;
    bus.iobus_datao_clear   = 1'b1;
    bus.iobus_datao_set     = 1'b1;
    bus.iobus_cono_clear    = 1'b1;
    bus.iobus_cono_set      = 1'b1;
    #1;
    checkOutput("desel_iob_out", bus.iobus_iob_out, 36'o0);
    tick();
    checkOutput("desel_tx_valid", 36'(bus.tx_valid), 36'd0);
    bus.iobus_datao_clear   = 1'b0;
    bus.iobus_datao_set     = 1'b0;
    bus.iobus_cono_clear    = 1'b0;
    bus.iobus_cono_set      = 1'b0;
    bus.iobus_iob_fm_datai  = 1'b0;
    bus.iobus_iob_fm_status = 1'b0;
    bus.iobus_ios           = DEV;
    readConi(v);
    checkOutput("desel_coni", v, 36'o3);
    readDatai(v);
    checkOutput("desel_datai", v, WORD);

    // Bus reset after the third character aborts the transfer.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, WORD);
    repeat (3) tick();
    checkOutput("abort_char4", 36'(bus.tx_data), 36'o04);
    bus.iobus_iob_reset = 1'b1;
    tick();
    bus.iobus_iob_reset = 1'b0;
    checkOutput("abort_tx_valid", 36'(bus.tx_valid), 36'd0);
    readConi(v);
    checkOutput("abort_coni", v, 36'o0);
    readDatai(v);
    checkOutput("abort_datai", v, 36'o0);
    repeat (8) tick();
    readConi(v);
    checkOutput("abort_no_done", v, 36'o0);
    checkOutput("abort_pi_req", 36'(bus.iobus_pi_req), 36'd0);
    checkOutput("abort_idle_valid", 36'(bus.tx_valid), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
